qsn_shift_sequencer: RTL and testbench
======================================

Name: qsn_shift_sequencer

Overview:
Control stage directly upstream of the shared quasi-cyclic shift network (QSN) used for CNU message permutation. It holds a programmable table of per-layer, per-submatrix shift factors and source selections. On each layer start it issues one entry per cycle as shift_factor, sw_in_src and one-hot sw_in_bit0_src to the shared QSN. It tracks the permutation pipeline latency so that downstream capture logic gets an aligned out_valid and a layer-complete pulse.

Parameters:
CHECK_PARALLELISM, 255, permutation length; legal shift range is 0..CHECK_PARALLELISM-1
BITWIDTH_SHIFT_FACTOR, $clog2(CHECK_PARALLELISM-1), shift_factor width (8 at default)
LAYER_NUM, 4, number of decoding layers in the table
SUB_NUM, 3, submatrix entries issued per layer (must be >=1)
PERM_LATENCY, 3, cycles from a registered select to valid QSN output (controller register plus BS_PIPELINE_LEVEL)

Ports:
sys_clk  in  1  clock
rstn  in  1  asynchronous active-low reset
cfg_we  in  1  table write strobe
cfg_addr  in  $clog2(LAYER_NUM*SUB_NUM)  entry index = layer*SUB_NUM+sub
cfg_data  in  BITWIDTH_SHIFT_FACTOR+2  {shift[BITWIDTH_SHIFT_FACTOR-1:0], src_code[1:0]}
start  in  1  single-cycle layer start request
layer_id  in  $clog2(LAYER_NUM)  layer to issue; sampled with start
stall  in  1  downstream back-pressure; blocks issuing
err_clr  in  1  clears err_flags
shift_factor  out  BITWIDTH_SHIFT_FACTOR  to QSN controller
sw_in_src  out  1  bit1..bit3 input mux select
sw_in_bit0_src  out  3  one-hot bit0 source select
sel_valid  out  1  current select set is a real issue
out_valid  out  1  sel_valid delayed PERM_LATENCY cycles
busy  out  1  high outside IDLE
layer_done  out  1  single-cycle completion pulse
err_flags  out  2  sticky: [0] illegal entry issued, [1] cfg write while busy

Behaviour:
- Reset, async assert and sync release: state IDLE; all outputs 0 except sw_in_bit0_src=3'b001; table entries all 0; valid delay line cleared. Reset mid-layer aborts the layer with no layer_done.
- Table writes are accepted only when busy=0. Write visible to an issue starting the next cycle. A write with busy=1 is dropped and sets err_flags[1].
- FSM IDLE -> ISSUE on start (layer_id latched). start while busy is ignored and no error is raised.
- ISSUE: sub counter 0..SUB_NUM-1.
  - Each cycle with stall=0 it registers the entry onto outputs with sel_valid=1 and increments the counter.
  - With stall=1: sel_valid=0, counter held, select outputs hold their last value.
  - After issuing sub SUB_NUM-1 it moves to DRAIN.
- DRAIN: waits until the delay line is empty. Then layer_done=1 for one cycle and the FSM returns to IDLE. busy drops in the same cycle as layer_done.
- Timing: start at cycle T gives the first sel_valid at T+1. out_valid for that issue is at T+1+PERM_LATENCY. layer_done comes one cycle after the final out_valid.
- Entry decode, with outputs registered:
  - src_code 0: sw_in_src=0, bit0_src=001
  - src_code 1: sw_in_src=1, bit0_src=010
  - src_code 2: sw_in_src=1, bit0_src=100
  - src_code 3: decoded as code 0 and sets err_flags[0]
- Shift >= CHECK_PARALLELISM: shift_factor driven 0 and err_flags[0] set. Issue continues.
- When sel_valid=0 outside stall, shift_factor=0 and sw_in_bit0_src=001.
- The delay line shifts every cycle and is unaffected by stall.
- err_flags are sticky until err_clr. If a set condition and err_clr occur in the same cycle, set wins.

Test Plan:
- Reset, then write layer 1 entries {5,0},{200,1},{17,2}; start layer_id=1 at T -> T+1..T+3 sel_valid=1 with shift 5/200/17, sw_in_src 0/1/1, bit0_src 001/010/100; out_valid T+4..T+6; layer_done at T+7.
- Same layer with stall=1 at T+2 only -> sel_valid pattern 1,0,1,1; shift 200 issued at T+3; layer_done at T+8.
- Entry {255,3} issued -> shift_factor=0, sw_in_src=0, bit0_src=001, err_flags=01. err_clr -> 00.
- cfg_we during ISSUE -> table unchanged on a later readback issue, err_flags[1]=1. start during busy -> no second layer_done.
- Assert rstn=0 asynchronously mid-ISSUE -> outputs immediately reset values, no out_valid or layer_done afterward. The next start works normally with a zeroed table (shift 0, code 0).
- Back-to-back: start asserted in the cycle after layer_done -> accepted, first sel_valid one cycle later.

Source files
------------

// File: rtl/qsn_shift_sequencer_if.sv
// Handshake and select bundle between the QSN shift sequencer and its configuration/control
// master; the master modport drives the config and control inputs.
interface qsn_shift_sequencer_if #(
  parameter int unsigned CHECK_PARALLELISM     = 255,
  parameter int unsigned BITWIDTH_SHIFT_FACTOR = $clog2(CHECK_PARALLELISM - 1),
  parameter int unsigned LAYER_NUM             = 4,
  parameter int unsigned SUB_NUM               = 3
);
  localparam int unsigned AddrW  = (LAYER_NUM * SUB_NUM > 1) ? $clog2(LAYER_NUM * SUB_NUM) : 1;
  localparam int unsigned LayerW = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1;

  logic                             cfg_we;
  logic [AddrW-1:0]                 cfg_addr;
  logic [BITWIDTH_SHIFT_FACTOR+1:0] cfg_data;
  logic                             start;
  logic [LayerW-1:0]                layer_id;
  logic                             stall;
  logic                             err_clr;
  logic [BITWIDTH_SHIFT_FACTOR-1:0] shift_factor;
  logic                             sw_in_src;
  logic [2:0]                       sw_in_bit0_src;
  logic                             sel_valid;
  logic                             out_valid;
  logic                             busy;
  logic                             layer_done;
  logic [1:0]                       err_flags;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, layer_id, stall, err_clr,
    input  shift_factor, sw_in_src, sw_in_bit0_src, sel_valid, out_valid, busy, layer_done,
           err_flags
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, layer_id, stall, err_clr,
    output shift_factor, sw_in_src, sw_in_bit0_src, sel_valid, out_valid, busy, layer_done,
           err_flags
  );
endinterface

// File: rtl/qsn_shift_sequencer.sv
// Issues per-layer shift/select entries to the shared QSN, one per cycle, and tracks the
// permutation latency to produce an aligned out_valid and a layer completion pulse.
module qsn_shift_sequencer #(
  parameter int unsigned CHECK_PARALLELISM     = 255,
  parameter int unsigned BITWIDTH_SHIFT_FACTOR = $clog2(CHECK_PARALLELISM - 1),
  parameter int unsigned LAYER_NUM             = 4,
  parameter int unsigned SUB_NUM               = 3,
  parameter int unsigned PERM_LATENCY          = 3
) (
  input logic                 sys_clk,
  input logic                 rstn,
  qsn_shift_sequencer_if.slave bus
);
  localparam int unsigned Entries = LAYER_NUM * SUB_NUM;
  localparam int unsigned AddrW   = (Entries > 1) ? $clog2(Entries) : 1;
  localparam int unsigned LayerW  = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1;
  localparam int unsigned SubW    = (SUB_NUM > 1) ? $clog2(SUB_NUM) : 1;
  localparam int unsigned EntryW  = BITWIDTH_SHIFT_FACTOR + 2;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  // Asserts asynchronously, releases two clocks after rstn rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) rst_sync_q <= 2'b00;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e                           state_q, state_d;
  logic [LayerW-1:0]                layer_q, layer_d, rd_layer;
  logic [SubW-1:0]                  sub_q, sub_d, rd_sub;
  logic [EntryW-1:0]                table_q [Entries];
  logic [AddrW-1:0]                 rd_idx;
  logic [EntryW-1:0]                rd_entry;
  logic [BITWIDTH_SHIFT_FACTOR-1:0] rd_shift, shift_q, shift_d;
  logic [1:0]                       rd_code;
  logic                             src_q, src_d;
  logic [2:0]                       bit0_q, bit0_d;
  logic                             sel_valid_q, sel_valid_d;
  logic [PERM_LATENCY-1:0]          pipe_q, pipe_d;
  logic [PERM_LATENCY:0]            line;
  logic                             done_q, done_d;
  logic [1:0]                       err_q, err_d;
  logic                             issue_en, bad_shift, busy, tbl_we;

  assign busy   = (state_q != StIdle);
  assign tbl_we = bus.cfg_we && !busy && (32'(bus.cfg_addr) < Entries);
  assign line   = {pipe_q, sel_valid_q};
  assign pipe_d = line[PERM_LATENCY-1:0];

  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    sub_d    = sub_q;
    done_d   = 1'b0;
    issue_en = 1'b0;
    rd_layer = layer_q;
    rd_sub   = sub_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          // The first entry is registered on the start edge so sel_valid follows by one cycle.
          layer_d  = bus.layer_id;
          rd_layer = bus.layer_id;
          rd_sub   = '0;
          sub_d    = '0;
          state_d  = StIssue;
          if (!bus.stall) begin
            issue_en = 1'b1;
            if (SUB_NUM == 1) state_d = StDrain;
            else              sub_d   = SubW'(1);
          end
        end
      end
      StIssue: begin
        if (!bus.stall) begin
          issue_en = 1'b1;
          if (sub_q == SubW'(SUB_NUM - 1)) state_d = StDrain;
          else                             sub_d   = sub_q + SubW'(1);
        end
      end
      StDrain: begin
        // Leave once nothing will remain in flight after this edge.
        if (pipe_d == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    rd_idx    = AddrW'(32'(rd_layer) * SUB_NUM + 32'(rd_sub));
    rd_entry  = table_q[rd_idx];
    rd_shift  = rd_entry[EntryW-1:2];
    rd_code   = rd_entry[1:0];
    bad_shift = (32'(rd_shift) >= CHECK_PARALLELISM);

    sel_valid_d = 1'b0;
    shift_d     = '0;
    src_d       = 1'b0;
    bit0_d      = 3'b001;
    if (issue_en) begin
      sel_valid_d = 1'b1;
      shift_d     = bad_shift ? '0 : rd_shift;
      case (rd_code)
        2'd1: begin
          src_d  = 1'b1;
          bit0_d = 3'b010;
        end
        2'd2: begin
          src_d  = 1'b1;
          bit0_d = 3'b100;
        end
        default: ;
      endcase
    end else if (state_q == StIssue && bus.stall) begin
      shift_d = shift_q;
      src_d   = src_q;
      bit0_d  = bit0_q;
    end

    err_d = (bus.err_clr ? 2'b00 : err_q) |
            {bus.cfg_we & busy, issue_en & (bad_shift | (rd_code == 2'b11))};
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      layer_q     <= '0;
      sub_q       <= '0;
      shift_q     <= '0;
      src_q       <= 1'b0;
      bit0_q      <= 3'b001;
      sel_valid_q <= 1'b0;
      pipe_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      sub_q       <= sub_d;
      shift_q     <= shift_d;
      src_q       <= src_d;
      bit0_q      <= bit0_d;
      sel_valid_q <= sel_valid_d;
      pipe_q      <= pipe_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Entries); i++) table_q[i] <= '0;
    end else if (tbl_we) begin
      table_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  assign bus.shift_factor   = shift_q;
  assign bus.sw_in_src      = src_q;
  assign bus.sw_in_bit0_src = bit0_q;
  assign bus.sel_valid      = sel_valid_q;
  assign bus.out_valid      = pipe_q[PERM_LATENCY-1];
  assign bus.busy           = busy;
  assign bus.layer_done     = done_q;
  assign bus.err_flags      = err_q;
endmodule

// File: tb/tb_qsn_shift_sequencer.sv
// Scoreboard bench for qsn_shift_sequencer: expected select sets are queued from a table
// model at start time and popped whenever sel_valid is observed.
module tb_qsn_shift_sequencer;
  localparam int unsigned CP   = 255;
  localparam int unsigned BW   = 8;
  localparam int unsigned LN   = 4;
  localparam int unsigned SN   = 3;
  localparam int unsigned PL   = 3;
  localparam int          NOBS = 18;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  qsn_shift_sequencer_if #(
    .CHECK_PARALLELISM(CP), .BITWIDTH_SHIFT_FACTOR(BW), .LAYER_NUM(LN), .SUB_NUM(SN)
  ) bus ();

  qsn_shift_sequencer #(
    .CHECK_PARALLELISM(CP), .BITWIDTH_SHIFT_FACTOR(BW), .LAYER_NUM(LN), .SUB_NUM(SN),
    .PERM_LATENCY(PL)
  ) dut (
    .sys_clk(clk),
    .rstn   (rstn),
    .bus    (bus)
  );

  typedef struct packed {
    logic [7:0] sh;
    logic       src;
    logic [2:0] b0;
  } sel_t;

  sel_t       exp_q[$];
  logic [9:0] model_tab [LN*SN];
  int         errors = 0;
  int         checks = 0;

  sel_t       ob_sel  [NOBS];
  logic       ob_sv   [NOBS];
  logic       ob_ov   [NOBS];
  logic       ob_done [NOBS];
  logic       ob_busy [NOBS];
  logic [1:0] ob_err  [NOBS];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input logic [7:0] sh, input logic [1:0] code);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'(addr);
    bus.cfg_data = {sh, code};
    tick();
    bus.cfg_we = 1'b0;
    model_tab[addr] = {sh, code};
  endtask

  task automatic push_expected(input int layer);
    for (int s = 0; s < int'(SN); s++) begin
      logic [9:0] e;
      sel_t       x;
      e    = model_tab[layer*int'(SN)+s];
      x.sh = (32'(e[9:2]) >= CP) ? 8'd0 : e[9:2];
      case (e[1:0])
        2'd1:    begin x.src = 1'b1; x.b0 = 3'b010; end
        2'd2:    begin x.src = 1'b1; x.b0 = 3'b100; end
        default: begin x.src = 1'b0; x.b0 = 3'b001; end
      endcase
      exp_q.push_back(x);
    end
  endtask

  // Start `layer` in the current cycle T and record outputs for cycles T+1..T+NOBS-1.
  task automatic run_layer(input int layer, input int stall_cyc, input int restart_cyc,
                           input int we_cyc);
    bus.layer_id = 2'(layer);
    bus.start    = 1'b1;
    bus.stall    = (stall_cyc == 0);
    for (int i = 1; i < NOBS; i++) begin
      tick();
      ob_sv[i]   = bus.sel_valid;
      ob_sel[i]  = {bus.shift_factor, bus.sw_in_src, bus.sw_in_bit0_src};
      ob_ov[i]   = bus.out_valid;
      ob_done[i] = bus.layer_done;
      ob_busy[i] = bus.busy;
      ob_err[i]  = bus.err_flags;
      bus.start  = (i == restart_cyc);
      bus.stall  = (i == stall_cyc);
      bus.cfg_we = (i == we_cyc);
      if (i == we_cyc) begin
        bus.cfg_addr = 4'(layer * int'(SN));
        bus.cfg_data = {8'd99, 2'd1};
      end
    end
    bus.start  = 1'b0;
    bus.stall  = 1'b0;
    bus.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus.sel_valid, bus.out_valid, bus.busy, bus.layer_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000",
               {bus.sel_valid, bus.out_valid, bus.busy, bus.layer_done});
    end
    checks++;
    if ({bus.shift_factor, bus.sw_in_src, bus.sw_in_bit0_src} !== {8'd0, 1'b0, 3'b001}) begin
      errors++;
      $display("FAIL reset_sel: got %h/%b/%b required 0/0/001",
               bus.shift_factor, bus.sw_in_src, bus.sw_in_bit0_src);
    end
    checks++;
    if (bus.err_flags !== 2'b00) begin
      errors++;
      $display("FAIL reset_err: got %b required 00", bus.err_flags);
    end
    #2 rstn = 1'b1;
    repeat (4) tick();
    checks++;
    if ({bus.busy, bus.sel_valid, bus.sw_in_bit0_src} !== 5'b00001) begin
      errors++;
      $display("FAIL post_reset_idle: got %b required 00001",
               {bus.busy, bus.sel_valid, bus.sw_in_bit0_src});
    end
  endtask

  task automatic test_basic();
    sel_t e;
    cfg_write(3, 8'd5, 2'd0);
    cfg_write(4, 8'd200, 2'd1);
    cfg_write(5, 8'd17, 2'd2);
    push_expected(1);
    run_layer(1, -1, -1, -1);
    for (int i = 1; i < NOBS; i++) begin
      checks++;
      if (ob_sv[i] !== 1'(i >= 1 && i <= 3)) begin
        errors++;
        $display("FAIL basic_sel_valid T+%0d: got %b required %b", i, ob_sv[i], i <= 3);
      end
      checks++;
      if (ob_ov[i] !== 1'(i >= 4 && i <= 6)) begin
        errors++;
        $display("FAIL basic_out_valid T+%0d: got %b required %b", i, ob_ov[i], i >= 4 && i <= 6);
      end
      checks++;
      if (ob_done[i] !== 1'(i == 7) || ob_busy[i] !== 1'(i <= 6)) begin
        errors++;
        $display("FAIL basic_done_busy T+%0d: got %b/%b required %b/%b", i, ob_done[i],
                 ob_busy[i], i == 7, i <= 6);
      end
      if (ob_sv[i] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL basic_issue T+%0d: got %h required no issue", i, ob_sel[i]);
        end else begin
          e = exp_q.pop_front();
          if (ob_sel[i] !== e) begin
            errors++;
            $display("FAIL basic_issue T+%0d: got %h required %h", i, ob_sel[i], e);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_left: got %0d unissued required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_stall();
    sel_t e;
    push_expected(1);
    run_layer(1, 1, -1, -1);
    for (int i = 1; i < NOBS; i++) begin
      checks++;
      if (ob_sv[i] !== 1'(i == 1 || i == 3 || i == 4)) begin
        errors++;
        $display("FAIL stall_sel_valid T+%0d: got %b required %b", i, ob_sv[i],
                 i == 1 || i == 3 || i == 4);
      end
      checks++;
      if (ob_ov[i] !== 1'(i == 4 || i == 6 || i == 7) || ob_done[i] !== 1'(i == 8)) begin
        errors++;
        $display("FAIL stall_ov_done T+%0d: got %b/%b required %b/%b", i, ob_ov[i], ob_done[i],
                 i == 4 || i == 6 || i == 7, i == 8);
      end
      if (ob_sv[i] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stall_issue T+%0d: got %h required no issue", i, ob_sel[i]);
        end else begin
          e = exp_q.pop_front();
          if (ob_sel[i] !== e) begin
            errors++;
            $display("FAIL stall_issue T+%0d: got %h required %h", i, ob_sel[i], e);
          end
        end
      end
    end
    checks++;
    if (ob_sel[2] !== {8'd5, 1'b0, 3'b001}) begin
      errors++;
      $display("FAIL stall_hold: got %h required %h", ob_sel[2], {8'd5, 1'b0, 3'b001});
    end
    exp_q.delete();
  endtask

  task automatic test_illegal();
    sel_t e;
    cfg_write(6, 8'd255, 2'd3);
    cfg_write(7, 8'd10, 2'd3);
    cfg_write(8, 8'd254, 2'd0);
    push_expected(2);
    run_layer(2, -1, -1, -1);
    for (int i = 1; i < NOBS; i++) begin
      if (ob_sv[i] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL illegal_issue T+%0d: got %h required no issue", i, ob_sel[i]);
        end else begin
          e = exp_q.pop_front();
          if (ob_sel[i] !== e) begin
            errors++;
            $display("FAIL illegal_issue T+%0d: got %h required %h", i, ob_sel[i], e);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || ob_done[7] !== 1'b1) begin
      errors++;
      $display("FAIL illegal_complete: got left=%0d done=%b required 0/1", exp_q.size(),
               ob_done[7]);
      exp_q.delete();
    end
    checks++;
    if (ob_err[1] !== 2'b01 || ob_err[NOBS-1] !== 2'b01) begin
      errors++;
      $display("FAIL illegal_err: got %b/%b required 01/01", ob_err[1], ob_err[NOBS-1]);
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    checks++;
    if (bus.err_flags !== 2'b00) begin
      errors++;
      $display("FAIL illegal_clr: got %b required 00", bus.err_flags);
    end
  endtask

  task automatic test_busy_write();
    sel_t e;
    int   ndone;
    cfg_write(0, 8'd1, 2'd0);
    cfg_write(1, 8'd2, 2'd1);
    cfg_write(2, 8'd3, 2'd2);
    for (int pass = 0; pass < 2; pass++) begin
      push_expected(0);
      // First pass: cfg write and a second start both land while busy.
      if (pass == 0) run_layer(0, -1, 2, 2);
      else           run_layer(0, -1, -1, -1);
      ndone = 0;
      for (int i = 1; i < NOBS; i++) begin
        if (ob_done[i] === 1'b1) ndone++;
        if (ob_sv[i] === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL busy_issue p%0d T+%0d: got %h required no issue", pass, i, ob_sel[i]);
          end else begin
            e = exp_q.pop_front();
            if (ob_sel[i] !== e) begin
              errors++;
              $display("FAIL busy_issue p%0d T+%0d: got %h required %h", pass, i, ob_sel[i], e);
            end
          end
        end
      end
      checks++;
      if (ndone != 1 || ob_done[7] !== 1'b1) begin
        errors++;
        $display("FAIL busy_done p%0d: got count=%0d at7=%b required 1/1", pass, ndone,
                 ob_done[7]);
      end
      checks++;
      if (ob_err[NOBS-1] !== 2'b10) begin
        errors++;
        $display("FAIL busy_err p%0d: got %b required 10", pass, ob_err[NOBS-1]);
      end
      exp_q.delete();
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    sel_t e;
    int   nlate;
    cfg_write(9, 8'd7, 2'd1);
    cfg_write(10, 8'd8, 2'd2);
    cfg_write(11, 8'd9, 2'd0);
    bus.layer_id = 2'd3;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.sel_valid !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got sv=%b busy=%b required 1/1", bus.sel_valid, bus.busy);
    end
    #3 rstn = 1'b0;
    #1;
    checks++;
    if ({bus.sel_valid, bus.busy, bus.out_valid, bus.shift_factor, bus.sw_in_src,
         bus.sw_in_bit0_src} !== {3'b000, 8'd0, 1'b0, 3'b001}) begin
      errors++;
      $display("FAIL areset_immediate: got sv=%b busy=%b ov=%b sh=%0d src=%b b0=%b",
               bus.sel_valid, bus.busy, bus.out_valid, bus.shift_factor, bus.sw_in_src,
               bus.sw_in_bit0_src);
    end
    repeat (2) tick();
    #2 rstn = 1'b1;
    nlate = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid === 1'b1 || bus.layer_done === 1'b1) nlate++;
    end
    checks++;
    if (nlate != 0) begin
      errors++;
      $display("FAIL areset_aborted: got %0d late out_valid/layer_done cycles required 0", nlate);
    end
    for (int k = 0; k < int'(LN*SN); k++) model_tab[k] = '0;
    push_expected(3);
    run_layer(3, -1, -1, -1);
    for (int i = 1; i < NOBS; i++) begin
      if (ob_sv[i] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL areset_issue T+%0d: got %h required no issue", i, ob_sel[i]);
        end else begin
          e = exp_q.pop_front();
          if (ob_sel[i] !== e) begin
            errors++;
            $display("FAIL areset_issue T+%0d: got %h required %h", i, ob_sel[i], e);
          end
        end
      end
    end
    checks++;
    if (ob_sv[1] !== 1'b1 || ob_done[7] !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL areset_restart: got sv1=%b done7=%b left=%0d required 1/1/0", ob_sv[1],
               ob_done[7], exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    sel_t e;
    cfg_write(3, 8'd5, 2'd0);
    cfg_write(4, 8'd200, 2'd1);
    cfg_write(5, 8'd17, 2'd2);
    push_expected(1);
    push_expected(1);
    run_layer(1, -1, 7, -1);
    for (int i = 1; i < NOBS; i++) begin
      checks++;
      if (ob_sv[i] !== 1'((i >= 1 && i <= 3) || (i >= 8 && i <= 10)) ||
          ob_done[i] !== 1'(i == 7 || i == 14)) begin
        errors++;
        $display("FAIL b2b_timing T+%0d: got sv=%b done=%b", i, ob_sv[i], ob_done[i]);
      end
      if (ob_sv[i] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_issue T+%0d: got %h required no issue", i, ob_sel[i]);
        end else begin
          e = exp_q.pop_front();
          if (ob_sel[i] !== e) begin
            errors++;
            $display("FAIL b2b_issue T+%0d: got %h required %h", i, ob_sel[i], e);
          end
        end
      end
    end
    checks++;
    if (ob_busy[7] !== 1'b0 || ob_busy[8] !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_busy: got busy7=%b busy8=%b left=%0d required 0/1/0", ob_busy[7],
               ob_busy[8], exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.start    = 1'b0;
    bus.layer_id = '0;
    bus.stall    = 1'b0;
    bus.err_clr  = 1'b0;
    for (int k = 0; k < int'(LN*SN); k++) model_tab[k] = '0;
    test_reset();
    test_basic();
    test_stall();
    test_illegal();
    test_busy_write();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
